io_sched: RTL and testbench

Sequencing controller and two-way arbiter for the 8-bit I/O register. It sits between the CPU control unit (requester 0) and the program loader (requester 1), and is the only source of the register's `in_en`, `out_en`, `port_in`, `port_out` and `clr` strobes. It accepts one operation at a time, drives the strobes in the correct order and for the correct duration, and signals completion. Strobe exclusivity on the shared data bus and external port is guaranteed by construction.

---
 rtl/io_sched_pkg.sv | 49 ++++
 rtl/io_sched_if.sv | 24 ++
 rtl/io_sched_rr_arb2.sv | 33 +++
 rtl/io_sched.sv | 109 ++++++++++
 tb/tb_io_sched.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/io_sched_pkg.sv
// Shared types for the I/O register sequencer: op codes, FSM states, strobe bundle.
package io_sched_pkg;

  localparam int unsigned HOLD_MIN = 1;
  localparam int unsigned HOLD_MAX = 15;
  localparam int unsigned NREQ     = 2;
  localparam int unsigned OP_W     = 2;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'b00,
    OP_LOAD   = 2'b01,
    OP_STORE  = 2'b10,
    OP_SAMPLE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_DRIVE,
    ST_CAPT,
    ST_PRESENT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic in_en;
    logic out_en;
    logic port_in;
    logic port_out;
    logic clr;
  } strobe_t;

  // One strobe per active state; IDLE and DONE drive nothing.
  function automatic strobe_t strobe_decode(input state_e s);
    strobe_t st;
    st = '0;
    case (s)
      ST_CLR:     st.clr      = 1'b1;
      ST_LOAD:    st.in_en    = 1'b1;
      ST_DRIVE:   st.port_out = 1'b1;
      ST_CAPT:    st.port_in  = 1'b1;
      ST_PRESENT: st.out_en   = 1'b1;
      default:    ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/io_sched_if.sv
// Requester-side handshake and I/O register strobe bundle for io_sched.
interface io_sched_if;
  logic       program_mode;
  logic [1:0] req;
  logic [3:0] op;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       in_en;
  logic       out_en;
  logic       port_in;
  logic       port_out;
  logic       clr;

  modport master (
    output program_mode, req, op,
    input  gnt, done, busy, in_en, out_en, port_in, port_out, clr
  );

  modport slave (
    input  program_mode, req, op,
    output gnt, done, busy, in_en, out_en, port_in, port_out, clr
  );
endinterface

// File: rtl/io_sched_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt_c
);

  logic last_q, last_d;

  always_comb begin
    gnt_c  = 2'b00;
    last_d = last_q;
    if (en) begin
      case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
        default: gnt_c = 2'b00;
      endcase
    end
    if (gnt_c[1])      last_d = 1'b1;
    else if (gnt_c[0]) last_d = 1'b0;
  end

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/io_sched.sv
// Sequencing controller for the 8-bit I/O register: arbitrates two requesters
// and drives the register strobes in order, one operation at a time.
module io_sched
  import io_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic       clk,
  input logic       rst,
  io_sched_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  state_e           state_q, state_d;
  logic [1:0]       own_q, own_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  strobe_t          stb_q, stb_d;

  logic [1:0] elig_c;
  logic [1:0] arb_gnt_c;
  op_e        win_op_c;

  assign elig_c   = bus.req & {1'b1, ~bus.program_mode};
  assign win_op_c = arb_gnt_c[1] ? op_e'(bus.op[3:2]) : op_e'(bus.op[1:0]);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst),
    .req   (elig_c),
    .en    (state_q == ST_IDLE),
    .gnt_c (arb_gnt_c)
  );

  // Next state; op and grant are captured only at acceptance.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt_c != 2'b00) begin
          own_d = arb_gnt_c;
          case (win_op_c)
            OP_CLEAR:  state_d = ST_CLR;
            OP_LOAD:   state_d = ST_LOAD;
            OP_STORE: begin
              state_d = ST_DRIVE;
              cnt_d   = CNT_W'(HOLD_CYCLES);
            end
            OP_SAMPLE: state_d = ST_CAPT;
          endcase
        end
      end
      ST_CLR, ST_LOAD, ST_PRESENT: state_d = ST_DONE;
      ST_DRIVE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_CAPT: state_d = ST_PRESENT;
      ST_DONE: begin
        state_d = ST_IDLE;
        own_d   = 2'b00;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    stb_d  = strobe_decode(state_d);
    busy_d = (state_d != ST_IDLE);
    gnt_d  = (state_d != ST_IDLE) ? own_d : 2'b00;
    done_d = (state_d == ST_DONE) ? own_d : 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      own_q   <= 2'b00;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.in_en    = stb_q.in_en;
  assign bus.out_en   = stb_q.out_en;
  assign bus.port_in  = stb_q.port_in;
  assign bus.port_out = stb_q.port_out;
  assign bus.clr      = stb_q.clr;

endmodule

// File: tb/tb_io_sched.sv
// Bench for io_sched: directed scenarios plus random requesters, all checked
// against a transaction-level model that expands each accepted op into its cycle list.
module tb_io_sched;
  import io_sched_pkg::*;

  localparam int unsigned HOLD = 4;
  localparam logic [4:0] S_IN   = 5'b10000;
  localparam logic [4:0] S_OUT  = 5'b01000;
  localparam logic [4:0] S_PIN  = 5'b00100;
  localparam logic [4:0] S_POUT = 5'b00010;
  localparam logic [4:0] S_CLR  = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  io_sched_if bus();

  io_sched #(.HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output word layout: {gnt[1:0], done[1:0], busy, in_en, out_en, port_in, port_out, clr}
  function automatic logic [9:0] dut_vec();
    return {bus.gnt, bus.done, bus.busy, bus.in_en, bus.out_en,
            bus.port_in, bus.port_out, bus.clr};
  endfunction

  logic [9:0] seq[$];
  logic       ptr_m;
  logic [9:0] exp_v;
  int         accepted;
  int         dones_seen;

  task automatic model_reset();
    seq.delete();
    ptr_m = 1'b1;
    exp_v = '0;
  endtask

  // Advance one clock: pop the next scheduled word, or arbitrate if idle.
  task automatic model_step(input logic [1:0] r, input logic [3:0] o, input logic pm);
    logic [1:0] el;
    logic [1:0] oh;
    logic [1:0] code;
    int w;
    if (seq.size() > 0) begin
      exp_v = seq.pop_front();
    end else begin
      el = r & {1'b1, ~pm};
      if (el == 2'b00) begin
        exp_v = '0;
      end else begin
        if (el == 2'b11) w = ptr_m ? 0 : 1;
        else             w = el[1] ? 1 : 0;
        ptr_m = (w == 1);
        oh    = (w == 1) ? 2'b10 : 2'b01;
        code  = (w == 1) ? o[3:2] : o[1:0];
        accepted++;
        case (code)
          2'd0: seq.push_back({oh, 2'b00, 1'b1, S_CLR});
          2'd1: seq.push_back({oh, 2'b00, 1'b1, S_IN});
          2'd2: for (int k = 0; k < int'(HOLD); k++) seq.push_back({oh, 2'b00, 1'b1, S_POUT});
          default: begin
            seq.push_back({oh, 2'b00, 1'b1, S_PIN});
            seq.push_back({oh, 2'b00, 1'b1, S_OUT});
          end
        endcase
        seq.push_back({oh, oh, 1'b1, 5'b00000});
        seq.push_back(10'b0);
        exp_v = seq.pop_front();
      end
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [3:0] o, input logic pm, input string tag);
    logic [4:0] stb;
    bus.req          = r;
    bus.op           = o;
    bus.program_mode = pm;
    model_step(r, o, pm);
    @(negedge clk);
    check(tag, 32'(dut_vec()), 32'(exp_v));
    stb = {bus.in_en, bus.out_en, bus.port_in, bus.port_out, bus.clr};
    check({tag, "_stb_excl"}, 32'($onehot0(stb)), 32'd1);
    check({tag, "_gnt_1hot"}, 32'($onehot0(bus.gnt)), 32'd1);
    dones_seen += $countones(bus.done);
  endtask

  logic [1:0] act;
  logic [3:0] ops;
  logic       pm_r;
  int         pout_cnt;

  initial begin
    rst = 1'b0;
    bus.req = 2'b00;
    bus.op = 4'h0;
    bus.program_mode = 1'b0;
    accepted = 0;
    dones_seen = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    rst = 1'b1;

    // Both requesters ask for LOAD: 0 first, then 1 in the next IDLE.
    step(2'b11, 4'b0101, 1'b0, "ld_both_acc");
    check("ld_both_first_gnt", 32'(bus.gnt), 32'h1);
    step(2'b11, 4'b0101, 1'b0, "ld_both_done0");
    step(2'b10, 4'b0101, 1'b0, "ld_both_idle");
    step(2'b10, 4'b0101, 1'b0, "ld_r1_acc");
    step(2'b10, 4'b0101, 1'b0, "ld_r1_done");
    step(2'b00, 4'b0101, 1'b0, "ld_r1_idle");

    // SAMPLE from requester 1.
    for (int i = 0; i < 3; i++) step(2'b10, 4'b1100, 1'b0, "smp_r1");
    step(2'b00, 4'b1100, 1'b0, "smp_r1_idle");

    // STORE from requester 0; req drops early but the hold is unchanged.
    pout_cnt = 0;
    for (int i = 0; i < int'(HOLD) + 1; i++) begin
      step((i < 2) ? 2'b01 : 2'b00, 4'b0010, 1'b0, "store_r0");
      pout_cnt += int'(bus.port_out);
    end
    check("store_hold_len", 32'(pout_cnt), 32'(HOLD));
    step(2'b00, 4'b0010, 1'b0, "store_idle");

    // program_mode masks requester 0's CLEAR; requester 1 LOAD wins.
    step(2'b11, 4'b0100, 1'b1, "pm_acc");
    check("pm_gnt_r1", 32'(bus.gnt), 32'h2);
    step(2'b11, 4'b0100, 1'b1, "pm_done");
    for (int i = 0; i < 4; i++) step(2'b01, 4'b0100, 1'b1, "pm_masked");

    // program_mode rising mid-SAMPLE does not abort requester 0.
    step(2'b01, 4'b0011, 1'b0, "pm_smp_acc");
    step(2'b01, 4'b0011, 1'b1, "pm_smp_out");
    step(2'b01, 4'b0011, 1'b1, "pm_smp_done");
    step(2'b00, 4'b0011, 1'b1, "pm_smp_idle");

    // Reset on the second DRIVE cycle aborts without done.
    step(2'b01, 4'b0010, 1'b0, "rst_store_d1");
    step(2'b01, 4'b0010, 1'b0, "rst_store_d2");
    rst = 1'b0;
    #1;
    check("rst_port_out", 32'(bus.port_out), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    bus.req = 2'b00;
    model_reset();
    @(negedge clk);
    check("rst_no_done", 32'(dut_vec()), 32'd0);
    rst = 1'b1;
    step(2'b01, 4'b0001, 1'b0, "post_rst_ld");
    step(2'b01, 4'b0001, 1'b0, "post_rst_done");
    step(2'b00, 4'b0001, 1'b0, "post_rst_idle");

    // Random requesters that honour the hold-until-done obligation.
    accepted = 0;
    dones_seen = 0;
    act = 2'b00;
    ops = 4'h0;
    pm_r = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (exp_v[6 + i]) act[i] = 1'b0;
        else if (!act[i] && $urandom_range(3) == 0) begin
          act[i] = 1'b1;
          ops[2*i +: 2] = 2'($urandom_range(3));
        end
      end
      if ($urandom_range(15) == 0) pm_r = ~pm_r;
      step(act, ops, pm_r, "stress");
    end
    for (int i = 0; i < 24 && seq.size() > 0; i++) step(2'b00, ops, pm_r, "drain");
    check("drain_empty", 32'(seq.size()), 32'd0);
    check("done_count", 32'(dones_seen), 32'(accepted));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
